// File: rtl/fifo_bram.sv
// fifo_bram: single-clock first-word-fall-through FIFO around an inferred
// dual-port block RAM. The RAM read port feeds a registered output stage, so
// the total capacity is the RAM depth plus one word held in out_data.
module fifo_bram #(
  parameter int WIDTH       = 8,
  parameter int ADDR_WIDTH  = 11,
  parameter int ALMOST_FULL = 2**ADDR_WIDTH - 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  // Pointer value that corresponds to a completely full RAM.
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] AF_LEVEL  = ALMOST_FULL[ADDR_WIDTH:0];

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q;
  logic [ADDR_WIDTH:0] ram_count;
  logic                push;
  logic                load;

  // Occupancy of the RAM alone; the wrap bit makes full and empty distinct.
  assign ram_count = wr_ptr_q - rd_ptr_q;

  // in_ready depends on registered pointers only, so a same-cycle pop never
  // frees a slot early and no path exists from out_ready to in_ready.
  assign in_ready = (ram_count != DEPTH_CNT);

  // Flush wins over any handshake in the same cycle.
  assign push = in_valid && in_ready && !flush;

  // Refill the output register whenever it is empty or being consumed.
  // Only entries already committed by the registered wr_ptr are read, so a
  // live read never collides with a write to the same address.
  assign load = (ram_count != '0) && (!out_valid_q || out_ready) && !flush;

  // Next-state for pointers and the output-valid flag.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (load) begin
        rd_ptr_d    = rd_ptr_q + PTR_ONE;
        out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Pointer and valid-flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
    end
  end

  // RAM write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= in_data;
    end
  end

  // RAM read port registered straight into the head-of-queue word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q <= '0;
    end else if (load) begin
      out_data_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign count       = ram_count + {{ADDR_WIDTH{1'b0}}, out_valid_q};
  assign full        = !in_ready;
  assign empty       = !out_valid_q;
  assign almost_full = (count >= AF_LEVEL);

endmodule

// File: tb/tb_fifo_bram.sv
// tb_fifo_bram: table-driven vectors, hand-written corner sequences and a
// queue-based reference model for randomized handshakes.
module tb_fifo_bram;

  localparam int W     = 8;
  localparam int AW    = 4;
  localparam int AF    = 12;
  localparam int DEPTH = 16;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          almost_full;

  fifo_bram #(.WIDTH(W), .ADDR_WIDTH(AW), .ALMOST_FULL(AF)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic         fl;
    logic         iv;
    logic [7:0]   d;
    logic         ordy;
    logic         e_ir;
    logic         e_ov;
    logic [7:0]   e_d;
    logic         cd;     // compare out_data for this vector
    int           e_cnt;
    logic         e_af;
  } vec_t;

  vec_t basic_v[7];
  vec_t fill_v[36];

  // Reference model: words held in the RAM, plus the output register.
  logic [7:0] ramq[$];
  logic       ov_m;
  logic [7:0] od_m;
  int         acc_words;

  function automatic vec_t mk(input logic fl, input logic iv, input logic [7:0] d,
                              input logic ordy, input logic e_ir, input logic e_ov,
                              input logic [7:0] e_d, input logic cd, input int e_cnt,
                              input logic e_af);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_d = e_d; v.cd = cd;
    v.e_cnt = e_cnt; v.e_af = e_af;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic e_ir, input logic e_ov,
                             input logic [7:0] e_d, input logic cd, input int e_cnt,
                             input logic e_af);
    check({tag, ".in_ready"},    32'(in_ready),    32'(e_ir));
    check({tag, ".full"},        32'(full),        32'(!e_ir));
    check({tag, ".out_valid"},   32'(out_valid),   32'(e_ov));
    check({tag, ".empty"},       32'(empty),       32'(!e_ov));
    check({tag, ".count"},       32'(count),       32'(e_cnt));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(e_af));
    if (cd) check({tag, ".out_data"}, 32'(out_data), 32'(e_d));
  endtask

  // Drive one vector, clock it, and compare the post-edge outputs.
  task automatic apply(input string tag, input vec_t v);
    flush     = v.fl;
    in_valid  = v.iv;
    in_data   = v.d;
    out_ready = v.ordy;
    @(posedge clk);
    #1;
    $display("[TB] %s fl=%0b iv=%0b d=%02h or=%0b -> ir=%0b ov=%0b d=%02h cnt=%0d af=%0b",
             tag, v.fl, v.iv, v.d, v.ordy, in_ready, out_valid, out_data, count, almost_full);
    check_state(tag, v.e_ir, v.e_ov, v.e_d, v.cd, v.e_cnt, v.e_af);
  endtask

  // Assert reset between edges; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    reset = 1'b1;
    #1;
    $display("[TB] %s reset asserted -> ov=%0b d=%02h cnt=%0d", tag, out_valid, out_data, count);
    check_state({tag, ".async"}, 1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    @(posedge clk);
    #1;
    check_state({tag, ".held"}, 1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    reset = 1'b0;
    ramq.delete();
    ov_m = 1'b0;
    od_m = 8'h00;
  endtask

  // One clock of randomized traffic checked against the queue model.
  task automatic model_step(input logic iv, input logic [7:0] d, input logic ordy);
    bit accept;
    bit take;
    bit consume;
    int cnt;
    accept  = iv && (ramq.size() != DEPTH);
    take    = (ramq.size() != 0) && (!ov_m || ordy);
    consume = ov_m && ordy;
    flush = 1'b0; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk);
    #1;
    if (take) begin
      od_m = ramq.pop_front();
      ov_m = 1'b1;
    end else if (consume) begin
      ov_m = 1'b0;
    end
    if (accept) begin
      ramq.push_back(d);
      acc_words++;
      if (acc_words % 1000 == 0)
        $display("[TB] random: %0d words accepted, depth %0d", acc_words, ramq.size() + int'(ov_m));
    end
    cnt = ramq.size() + int'(ov_m);
    check_state("rand", ramq.size() != DEPTH, ov_m, od_m, ov_m, cnt, cnt >= AF);
  endtask

  initial begin
    #5_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    ov_m = 1'b0; od_m = 8'h00; acc_words = 0;

    // Basic order: three pushes, then three pops.
    basic_v[0] = mk(0, 1, 8'h11, 0, 1, 0, 8'h00, 1, 1, 0);
    basic_v[1] = mk(0, 1, 8'h22, 0, 1, 1, 8'h11, 1, 2, 0);
    basic_v[2] = mk(0, 1, 8'h33, 0, 1, 1, 8'h11, 1, 3, 0);
    basic_v[3] = mk(0, 0, 8'h00, 0, 1, 1, 8'h11, 1, 3, 0);
    basic_v[4] = mk(0, 0, 8'h00, 1, 1, 1, 8'h22, 1, 2, 0);
    basic_v[5] = mk(0, 0, 8'h00, 1, 1, 1, 8'h33, 1, 1, 0);
    basic_v[6] = mk(0, 0, 8'h00, 1, 1, 0, 8'h33, 1, 0, 0);

    // Fill to 17 words, refuse an 18th, one pop, then drain.
    for (int k = 0; k < 17; k++)
      fill_v[k] = mk(0, 1, 8'(k), 0, k != 16, k >= 1, 8'h00, 1, k + 1, (k + 1) >= AF);
    fill_v[17] = mk(0, 1, 8'h11, 0, 0, 1, 8'h00, 1, 17, 1);
    fill_v[18] = mk(0, 1, 8'h11, 1, 1, 1, 8'h01, 1, 16, 1);
    fill_v[19] = mk(0, 0, 8'h00, 0, 1, 1, 8'h01, 1, 16, 1);
    for (int m = 0; m < 15; m++)
      fill_v[20 + m] = mk(0, 0, 8'h00, 1, 1, 1, 8'(m + 2), 1, 15 - m, (15 - m) >= AF);
    fill_v[35] = mk(0, 0, 8'h00, 1, 1, 0, 8'h10, 1, 0, 0);

    #3;
    do_reset("reset0");
    for (int i = 0; i < 7; i++) apply($sformatf("basic[%0d]", i), basic_v[i]);

    @(posedge clk); #1;
    do_reset("reset1");
    for (int i = 0; i < 36; i++) apply($sformatf("fill[%0d]", i), fill_v[i]);

    // Streaming across pointer wrap: output is input delayed by two edges.
    for (int t = 0; t < 100; t++) begin
      flush = 1'b0; in_valid = 1'b1; in_data = 8'(t); out_ready = 1'b1;
      @(posedge clk); #1;
      $display("[TB] stream[%0d] in=%02h -> ov=%0b d=%02h cnt=%0d", t, 8'(t), out_valid, out_data, count);
      check($sformatf("stream[%0d].out_valid", t), 32'(out_valid), 32'(t >= 1));
      check($sformatf("stream[%0d].in_ready", t), 32'(in_ready), 32'd1);
      check($sformatf("stream[%0d].count", t), 32'(count), (t == 0) ? 32'd1 : 32'd2);
      if (t >= 1) check($sformatf("stream[%0d].out_data", t), 32'(out_data), 32'(t - 1));
    end
    apply("stream.drain0", mk(0, 0, 8'h00, 1, 1, 1, 8'd99, 1, 1, 0));
    apply("stream.drain1", mk(0, 0, 8'h00, 1, 1, 0, 8'd99, 1, 0, 0));

    // Flush with a simultaneous push and pop; the pushed word is discarded.
    for (int i = 0; i < 5; i++)
      apply($sformatf("flush.push[%0d]", i),
            mk(0, 1, 8'(8'hA0 + i), 0, 1, i >= 1, 8'hA0, i >= 1, i + 1, 0));
    apply("flush.hit",   mk(1, 1, 8'hAA, 1, 1, 0, 8'h00, 0, 0, 0));
    apply("flush.push",  mk(0, 1, 8'h55, 0, 1, 0, 8'h00, 0, 1, 0));
    apply("flush.idle",  mk(0, 0, 8'h00, 0, 1, 1, 8'h55, 1, 1, 0));
    apply("flush.pop",   mk(0, 0, 8'h00, 1, 1, 0, 8'h55, 1, 0, 0));

    // Randomized 50% handshakes against the queue model.
    ramq.delete();
    ov_m = 1'b0;
    od_m = 8'h55;
    acc_words = 0;
    for (int cyc = 0; cyc < 60000 && acc_words < 10000; cyc++)
      model_step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    check("random.words_accepted", 32'(acc_words), 32'd10000);
    for (int cyc = 0; cyc < 40 && (ramq.size() != 0 || ov_m); cyc++)
      model_step(1'b0, 8'h00, 1'b1);
    check("random.drained", 32'(count), 32'd0);

    // Half full, then asynchronous reset mid-cycle, then basic order again.
    for (int i = 0; i < 8; i++) model_step(1'b1, 8'(8'hC0 + i), 1'b0);
    do_reset("reset2");
    for (int i = 0; i < 7; i++) apply($sformatf("basic2[%0d]", i), basic_v[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_bram.md
# fifo_bram

Parametrised first-word-fall-through FIFO built around an inferred dual-port block RAM. It generalises the fixed 2k×8 dual-port RAM used for sample and command buffering to any width and power-of-two depth. It adds pointer management, valid/ready handshakes on both sides, a registered output stage, an occupancy count, an almost-full threshold and a synchronous flush. It sits between the host-interface byte stream and the converter-side sample path, and can be used wherever a single-clock elastic buffer is needed.

## Interface
- WIDTH, 8: data word width in bits.
- ADDR_WIDTH, 11: RAM address width; RAM depth is 2^ADDR_WIDTH words.
- ALMOST_FULL, 2^ADDR_WIDTH − 16: count threshold for `almost_full`; must be ≤ 2^ADDR_WIDTH + 1.

- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of FIFO contents.
- in_valid  in  1  producer has a word on `in_data`.
- in_ready  out  1  FIFO can accept a word this cycle.
- in_data  in  WIDTH  write data.
- out_valid  out  1  `out_data` holds the oldest word.
- out_ready  in  1  consumer takes `out_data` this cycle.
- out_data  out  WIDTH  head-of-queue word, registered.
- count  out  ADDR_WIDTH+1  words held, counting both the RAM and the output register.
- full  out  1  equal to `!in_ready`.
- empty  out  1  equal to `!out_valid`.
- almost_full  out  1  high when `count >= ALMOST_FULL`.

## Operation
- Storage is a RAM with 2^ADDR_WIDTH entries, a synchronous write and a synchronous (registered) read. RAM contents are not reset.
- `wr_ptr` and `rd_ptr` are each ADDR_WIDTH+1 bits: the low bits address the RAM and the MSB is a wrap bit. `ram_count = wr_ptr − rd_ptr` (mod 2^(ADDR_WIDTH+1)), and ranges 0..2^ADDR_WIDTH.
- Push occurs when `in_valid && in_ready`. It writes `in_data` to `ram[wr_ptr]` and increments `wr_ptr`.
- `in_ready = (ram_count != 2^ADDR_WIDTH)`. It is computed from registered pointers only.
  - A pop in the same cycle does not raise `in_ready`; there is no bypass.
- Load condition: `load = (ram_count != 0) && (!out_valid || out_ready)`.
  - When `load` is true, `ram[rd_ptr]` is loaded into `out_data`, `out_valid` is set to 1 and `rd_ptr` is incremented.
- When `out_valid && out_ready && !load`, `out_valid` is cleared and `out_data` holds its value.
- `count = ram_count + out_valid`. Total capacity is 2^ADDR_WIDTH + 1 words.
- Flush: if `flush` is high at an edge, both pointers go to 0 and `out_valid` goes to 0. Flush has priority over a push or pop in the same cycle; that push is discarded and that pop is ignored.
- Reset, applied asynchronously: pointers = 0, `out_valid` = 0, `out_data` = 0. The outputs that follow from this are `in_ready` = 1, `count` = 0, `full` = 0, `empty` = 1 and `almost_full` = 0 (the last assumes ALMOST_FULL > 0).
- The RAM never sees a read and a write to the same address in the same cycle with a live read. This holds because reads only consume entries already counted by the registered `wr_ptr`.

## Timing
- Write-to-read latency into an empty FIFO is 2 edges. A word accepted at edge E0 appears with `out_valid` = 1 after edge E1.
- Steady streaming (`in_valid` = `out_ready` = 1) sustains 1 word per cycle in both directions. Pointers wrap silently past 2^ADDR_WIDTH.
- `count`, `full` and `almost_full` update on the edge following the handshake. No combinational path exists from `in_valid` or `out_ready` to any output.
- When full, a pop at edge E makes `in_ready` = 1 during the cycle after E, but only once the RAM drains one entry into the output register.
- Reset deasserting on an edge: the FIFO accepts its first push on the following edge.

## Test plan
- **Basic order.** ADDR_WIDTH=11. After reset, push 0x11, 0x22, 0x33 on consecutive cycles with `out_ready` = 0.
  - `out_valid` rises 2 edges after the first push with `out_data` = 0x11, and `count` = 3.
  - Then assert `out_ready` = 1: 0x11, 0x22, 0x33 pop on 3 consecutive edges, then `empty` = 1 and `count` = 0.
- **Fill and full.** ADDR_WIDTH=4, ALMOST_FULL=12. Push 0x00..0x10 (17 words) with `out_ready` = 0.
  - `almost_full` rises when `count` = 12.
  - After the 17th push: `in_ready` = 0, `full` = 1, `count` = 17, and a held 18th word is not accepted.
  - One pop: `out_data` moves 0x00 → 0x01, and `in_ready` = 1 on the next cycle.
- **Streaming wrap.** ADDR_WIDTH=4, incrementing data, `in_valid` = `out_ready` = 1 for 100 cycles.
  - Output sequence equals input sequence delayed 2 cycles, with 1 word per cycle after start and no gaps or drops across pointer wrap.
- **Random backpressure.** 10,000 words with random `in_valid`/`out_ready` at 50%, compared against a scoreboard.
  - Order is exact, `count` always equals the scoreboard depth, and no push is accepted while `full`.
- **Flush.** With 5 words held, assert `flush` together with a push of 0xAA and `out_ready` = 1.
  - Next cycle: `count` = 0, `out_valid` = 0, `in_ready` = 1.
  - A subsequent push of 0x55 emerges first; 0xAA never appears.
- **Asynchronous reset.** With the FIFO half full, assert `reset` mid-cycle between edges.
  - `out_valid`, `count` and `out_data` go to 0 immediately, without waiting for a clock edge.
  - After release, behaviour matches the basic-order scenario.
